// File: rtl/uart_pkg.sv
// ------------------------------------------------------------------
// uart_pkg: shared UART defaults, arbiter state encoding, clog2 helper.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_SEND  = 2'd2
  } arb_state_t;

  // Never returns less than 1 so single-entry ranges still get a bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ------------------------------------------------------------------
// uart_rr_pick: rotate-priority picker, first eligible request at or after ptr.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic [NUM_REQ-1:0] mask_i,
  output logic               found_o,
  output logic [PTR_W-1:0]   idx_o
);

  // Scan from the farthest offset down so the closest match to ptr wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[j] && mask_i[j]) begin
        found_o = 1'b1;
        idx_o   = PTR_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ------------------------------------------------------------------
// uart_tx_arbiter: round-robin sharing of one UART transmitter with frame lock.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = DATA_BITS_DEF,
  parameter int ACCEPT_TIMEOUT = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [clog2(NUM_REQ)-1:0]      grant_idx,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int PTR_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(ACCEPT_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_t             state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic                   lock_q;
  logic                   last_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [NUM_REQ-1:0]     req_ready_q;
  logic [DATA_BITS-1:0]   tx_data_q;
  logic                   tx_valid_q;
  logic [PTR_W-1:0]       grant_q;
  logic                   timeout_q;

  logic [NUM_REQ-1:0]     elig_mask;
  logic                   pick_found;
  logic [PTR_W-1:0]       pick_idx;
  logic [PTR_W-1:0]       ptr_next;

  // While a frame is locked, only the owner of the last grant may win.
  assign elig_mask = lock_q ? (NUM_REQ'(1) << grant_q) : {NUM_REQ{1'b1}};
  assign ptr_next  = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
  assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .mask_i  (elig_mask),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      grant_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      req_ready_q <= '0;
      timeout_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_ready && pick_found) begin
            tx_data_q   <= req_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
            grant_q     <= pick_idx;
            last_q      <= req_last[pick_idx];
            req_ready_q <= NUM_REQ'(1) << pick_idx;
            tx_valid_q  <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_SEND;
          end else if (cnt_q >= CNT_LAST) begin
            // Transmitter never took the byte: drop it and release the frame.
            tx_valid_q <= 1'b0;
            timeout_q  <= 1'b1;
            lock_q     <= 1'b0;
            ptr_q      <= ptr_next;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (last_q) begin
              lock_q <= 1'b0;
              ptr_q  <= ptr_next;
            end else begin
              lock_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign grant_idx   = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ------------------------------------------------------------------
// tb_uart_tx_arbiter: scoreboard bench with a behavioural transmitter model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int TO      = 16;
  localparam int FRAME   = 12;
  localparam int LIMIT   = 3000;
  localparam int M_NORM  = 0;
  localparam int M_TIE   = 1;
  localparam int M_LOW   = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] gap;
  } item_t;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*DW-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [DW-1:0]        tx_data;
  logic                 tx_valid;
  logic                 tx_ready = 1'b1;
  logic [1:0]           grant_idx;
  logic                 busy;
  logic                 timeout_err;

  item_t rq[NUM_REQ][$];
  exp_t  exp_q[$];
  int    hold[NUM_REQ];
  int    gap_cur[NUM_REQ];
  int    mode = M_NORM;
  bit    mrst = 1'b0;
  int    tcnt = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    n_pulses = 0;
  logic [NUM_REQ-1:0] prev_ready = '0;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_BITS      (DW),
    .ACCEPT_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic l, input int g);
    item_t it;
    it.data = d;
    it.last = l;
    it.gap  = 8'(g);
    rq[i].push_back(it);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic [1:0] idx);
    exp_t e;
    e.data = d;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  function automatic bit pending();
    bit p;
    p = (req_valid != '0);
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < LIMIT && (exp_q.size() != 0 || busy || !tx_ready || pending())) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < LIMIT), 32'd1);
    idle(3);
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst  = 1'b1;
    mrst = 1'b1;
    idle(cycles);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    check({tag, "_tx_data"},     32'(tx_data),     32'd0);
    check({tag, "_tx_valid"},    32'(tx_valid),    32'd0);
    check({tag, "_grant_idx"},   32'(grant_idx),   32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // Requester drivers: present the next queued byte, drop it on req_ready.
  initial begin
    item_t it;
    for (int i = 0; i < NUM_REQ; i++) begin
      hold[i]    = 0;
      gap_cur[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i]) begin
          if (req_ready[i]) begin
            req_valid[i] = 1'b0;
            hold[i]      = gap_cur[i];
          end
        end else if (hold[i] > 0) begin
          hold[i]--;
        end else if (rq[i].size() > 0) begin
          it = rq[i].pop_front();
          req_data[i*DW +: DW] = it.data;
          req_last[i]          = it.last;
          gap_cur[i]           = int'(it.gap);
          req_valid[i]         = 1'b1;
        end
      end
    end
  end

  // Transmitter model and scoreboard monitor: a byte is taken when tx_valid meets idle tx_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || mrst) begin
        tx_ready = 1'b1;
        tcnt     = 0;
        mrst     = 1'b0;
      end else if (mode == M_TIE) begin
        tx_ready = 1'b1;
      end else if (mode == M_LOW) begin
        tx_ready = 1'b0;
      end else if (tcnt > 0) begin
        tcnt--;
        if (tcnt == FRAME - 1) check("tx_valid_drop", 32'(tx_valid), 32'd0);
        if (tcnt == 0) tx_ready = 1'b1;
      end else if (!tx_ready) begin
        tx_ready = 1'b1;
      end else if (tx_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("grant_idx", 32'(grant_idx), 32'(e.idx));
        end
        tx_ready = 1'b0;
        tcnt     = FRAME;
      end
    end
  end

  // req_ready pulse shape monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        n_pulses++;
        check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        check("ready_single_cycle", 32'(prev_ready), 32'd0);
        check("ready_with_valid", 32'(tx_valid), 32'd1);
        check("ready_vs_grant", 32'(req_ready), 32'(4'(1) << grant_idx));
      end
      prev_ready = req_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    int  n;
    bit  bad;

    idle(4);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single request.
    expect_byte(8'hAA, 2'd0);
    load(0, 8'hAA, 1'b1, 0);
    drain("single_drain");

    // Round robin from ptr=0, then ptr=3 favours req3 over req0.
    pulse_reset(2);
    idle(2);
    expect_byte(8'h12, 2'd0);
    expect_byte(8'h34, 2'd1);
    expect_byte(8'h56, 2'd2);
    load(0, 8'h12, 1'b1, 0);
    load(1, 8'h34, 1'b1, 0);
    load(2, 8'h56, 1'b1, 0);
    drain("rr_drain");
    expect_byte(8'h43, 2'd3);
    expect_byte(8'h40, 2'd0);
    load(0, 8'h40, 1'b1, 0);
    load(3, 8'h43, 1'b1, 0);
    drain("rr_wrap_drain");

    // Frame lock with a 50-cycle gap inside req1's frame (ptr=1 here).
    expect_byte(8'hA1, 2'd1);
    expect_byte(8'hA2, 2'd1);
    expect_byte(8'hB0, 2'd0);
    load(1, 8'hA1, 1'b0, 50);
    load(1, 8'hA2, 1'b1, 0);
    load(0, 8'hB0, 1'b1, 0);
    drain("lock_drain");

    // Lock onto req2, then let its next byte time out.
    expect_byte(8'h11, 2'd2);
    load(2, 8'h11, 1'b0, 0);
    drain("pre_timeout_drain");
    mode = M_TIE;
    idle(2);
    load(2, 8'h5A, 1'b1, 0);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_valid_seen", 32'(tx_valid), 32'd1);
    cnt = 0;
    while (tx_valid && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_valid_cycles", 32'(cnt), 32'(TO));
    check("timeout_err_pulse", 32'(timeout_err), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("timeout_err_once", 32'(timeout_err), 32'd0);
    mode = M_NORM;
    idle(2);
    expect_byte(8'h63, 2'd3);
    expect_byte(8'h60, 2'd0);
    load(0, 8'h60, 1'b1, 0);
    load(3, 8'h63, 1'b1, 0);
    drain("post_timeout_drain");

    // Reset during SEND.
    expect_byte(8'hC3, 2'd1);
    load(1, 8'hC3, 1'b1, 0);
    n = 0;
    while (tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midframe_accepted", 32'(tx_ready), 32'd0);
    idle(3);
    check("midframe_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst  = 1'b1;
    mrst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midframe");
    rst = 1'b0;
    idle(2);
    expect_byte(8'h3C, 2'd2);
    load(2, 8'h3C, 1'b1, 0);
    drain("after_reset_drain");

    // Hold-off while the transmitter is not idle.
    mode = M_LOW;
    idle(2);
    load(0, 8'h77, 1'b1, 0);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready != '0 || tx_valid) bad = 1'b1;
    end
    check("holdoff_no_grant", 32'(bad), 32'd0);
    expect_byte(8'h77, 2'd0);
    mode = M_NORM;
    drain("holdoff_drain");

    check("ready_pulse_total", 32'(n_pulses), 32'd16);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
